// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: bundles the slot-stream inputs and the frame/status outputs
// of the 4:1 TDM demultiplexer.
//   din         W      slot data
//   din_valid   1      beat qualifier for din/sync
//   sync        1      frame-sync marker (channel 0 beat)
//   frame_out   4*W    last complete frame, ch0 in the low bits
//   frame_valid 1      one-cycle pulse when frame_out updates
//   slot        2      next expected slot index
//   locked      1      high while aligned
//   sync_err    1      one-cycle pulse per misalignment
//   err_count   ERRW   saturating sync-error count
// master: stream source / frame consumer side; slave: the demultiplexer.
interface tdm_demux4_if #(
   parameter int W    = 4,
   parameter int ERRW = 8
);
   logic [W-1:0]    din;
   logic            din_valid;
   logic            sync;
   logic [4*W-1:0]  frame_out;
   logic            frame_valid;
   logic [1:0]      slot;
   logic            locked;
   logic            sync_err;
   logic [ERRW-1:0] err_count;

   modport master (
      output din, din_valid, sync,
      input  frame_out, frame_valid, slot, locked, sync_err, err_count
   );

   modport slave (
      input  din, din_valid, sync,
      output frame_out, frame_valid, slot, locked, sync_err, err_count
   );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4:1 channel-multiplexed link. Aligns to the
// sync marker on channel 0, gathers four W-bit slots and publishes them as
// one parallel frame; reports lock status and sync errors.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  tdm_demux4_if.slave (din/din_valid/sync in; frame and status out)
module tdm_demux4 #(
   parameter int W    = 4,
   parameter int ERRW = 8
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux4_if.slave  bus
);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t          r_state,  w_state_nxt;
   logic [1:0]      r_slot,   w_slot_nxt;
   logic [W-1:0]    r_ch0,    w_ch0_nxt;
   logic [W-1:0]    r_ch1,    w_ch1_nxt;
   logic [W-1:0]    r_ch2,    w_ch2_nxt;
   logic [4*W-1:0]  r_frame,  w_frame_nxt;
   logic            r_fvalid, w_fvalid_nxt;
   logic            r_err,    w_err_nxt;
   logic [ERRW-1:0] r_cnt,    w_cnt_nxt;
   logic [ERRW-1:0] w_cnt_inc;

   // Saturating increment: holds at all-ones instead of wrapping.
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= HUNT;
         r_slot   <= '0;
         r_ch0    <= '0;
         r_ch1    <= '0;
         r_ch2    <= '0;
         r_frame  <= '0;
         r_fvalid <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_slot   <= w_slot_nxt;
         r_ch0    <= w_ch0_nxt;
         r_ch1    <= w_ch1_nxt;
         r_ch2    <= w_ch2_nxt;
         r_frame  <= w_frame_nxt;
         r_fvalid <= w_fvalid_nxt;
         r_err    <= w_err_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_slot_nxt   = r_slot;
      w_ch0_nxt    = r_ch0;
      w_ch1_nxt    = r_ch1;
      w_ch2_nxt    = r_ch2;
      w_frame_nxt  = r_frame;
      w_fvalid_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      w_cnt_nxt    = r_cnt;

      if (bus.din_valid) begin
         unique case (r_state)
            HUNT: begin
               if (bus.sync) begin
                  w_ch0_nxt   = bus.din;
                  w_slot_nxt  = 2'd1;
                  w_state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (bus.sync) begin
                  // Early sync abandons the partial frame; the beat still
                  // starts a fresh frame as ch0.
                  if (r_slot != 2'd0) begin
                     w_err_nxt = 1'b1;
                     w_cnt_nxt = w_cnt_inc;
                  end
                  w_ch0_nxt  = bus.din;
                  w_slot_nxt = 2'd1;
               end else if (r_slot == 2'd0) begin
                  w_err_nxt   = 1'b1;
                  w_cnt_nxt   = w_cnt_inc;
                  w_slot_nxt  = 2'd0;
                  w_state_nxt = HUNT;
               end else begin
                  unique case (r_slot)
                     2'd1: w_ch1_nxt = bus.din;
                     2'd2: w_ch2_nxt = bus.din;
                     default: begin
                        // ch3 goes straight into the frame with the others.
                        w_frame_nxt  = {bus.din, r_ch2, r_ch1, r_ch0};
                        w_fvalid_nxt = 1'b1;
                     end
                  endcase
                  w_slot_nxt = r_slot + 2'd1;
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   assign bus.frame_out   = r_frame;
   assign bus.frame_valid = r_fvalid;
   assign bus.slot        = r_slot;
   assign bus.locked      = (r_state == LOCKED);
   assign bus.sync_err    = r_err;
   assign bus.err_count   = r_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   tdm_demux4_if #(.W(4), .ERRW(8)) ifa ();
   tdm_demux4_if #(.W(4), .ERRW(2)) ifb ();

   tdm_demux4 #(.W(4), .ERRW(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   tdm_demux4 #(.W(4), .ERRW(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        s;
      logic [3:0]  d;
      logic [15:0] fo;
      logic        fv;
      logic [1:0]  sl;
      logic        lk;
      logic        se;
      logic [7:0]  ec;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic s, input logic [3:0] d,
                      input logic [15:0] fo, input logic fv, input logic [1:0] sl,
                      input logic lk, input logic se, input logic [7:0] ec);
      vec_t t;
      t.v = v; t.s = s; t.d = d; t.fo = fo; t.fv = fv;
      t.sl = sl; t.lk = lk; t.se = se; t.ec = ec;
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input logic [15:0] fo, input logic fv,
                        input logic [1:0] sl, input logic lk, input logic se,
                        input logic [7:0] ec);
      chk({nm, ".frame_out"},   32'(ifa.frame_out),   32'(fo));
      chk({nm, ".frame_valid"}, 32'(ifa.frame_valid), 32'(fv));
      chk({nm, ".slot"},        32'(ifa.slot),        32'(sl));
      chk({nm, ".locked"},      32'(ifa.locked),      32'(lk));
      chk({nm, ".sync_err"},    32'(ifa.sync_err),    32'(se));
      chk({nm, ".err_count"},   32'(ifa.err_count),   32'(ec));
   endtask

   task automatic beat_a(input logic v, input logic s, input logic [3:0] d);
      @(negedge clk);
      ifa.din_valid = v;
      ifa.sync      = s;
      ifa.din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic beat_b(input logic v, input logic s, input logic [3:0] d);
      @(negedge clk);
      ifb.din_valid = v;
      ifb.sync      = s;
      ifb.din       = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;

      // Basic frame 1,2,3,4
      add(1,1,4'h1, 16'h0000,0,2'd1,1,0,8'd0);
      add(1,0,4'h2, 16'h0000,0,2'd2,1,0,8'd0);
      add(1,0,4'h3, 16'h0000,0,2'd3,1,0,8'd0);
      add(1,0,4'h4, 16'h4321,1,2'd0,1,0,8'd0);
      add(0,0,4'h0, 16'h4321,0,2'd0,1,0,8'd0);
      // Same frame with idle gaps
      add(1,1,4'h1, 16'h4321,0,2'd1,1,0,8'd0);
      add(0,1,4'h9, 16'h4321,0,2'd1,1,0,8'd0);
      add(0,0,4'hF, 16'h4321,0,2'd1,1,0,8'd0);
      add(1,0,4'h2, 16'h4321,0,2'd2,1,0,8'd0);
      add(0,1,4'h0, 16'h4321,0,2'd2,1,0,8'd0);
      add(0,0,4'h0, 16'h4321,0,2'd2,1,0,8'd0);
      add(0,0,4'h0, 16'h4321,0,2'd2,1,0,8'd0);
      add(1,0,4'h3, 16'h4321,0,2'd3,1,0,8'd0);
      add(0,0,4'h0, 16'h4321,0,2'd3,1,0,8'd0);
      add(1,0,4'h4, 16'h4321,1,2'd0,1,0,8'd0);
      add(0,0,4'h0, 16'h4321,0,2'd0,1,0,8'd0);
      // Early sync: A=5,B=6, sync again on C=7, then D=8,E=9,F=A
      add(1,1,4'h5, 16'h4321,0,2'd1,1,0,8'd0);
      add(1,0,4'h6, 16'h4321,0,2'd2,1,0,8'd0);
      add(1,1,4'h7, 16'h4321,0,2'd1,1,1,8'd1);
      add(1,0,4'h8, 16'h4321,0,2'd2,1,0,8'd1);
      add(1,0,4'h9, 16'h4321,0,2'd3,1,0,8'd1);
      add(1,0,4'hA, 16'hA987,1,2'd0,1,0,8'd1);
      // Missing sync at slot 0
      add(1,0,4'h3, 16'hA987,0,2'd0,0,1,8'd2);
      // HUNT discards sync=0 beats
      add(1,0,4'h1, 16'hA987,0,2'd0,0,0,8'd2);
      add(1,0,4'h2, 16'hA987,0,2'd0,0,0,8'd2);
      add(0,1,4'h2, 16'hA987,0,2'd0,0,0,8'd2);
      // Relock and a clean frame
      add(1,1,4'h1, 16'hA987,0,2'd1,1,0,8'd2);
      add(1,0,4'h2, 16'hA987,0,2'd2,1,0,8'd2);
      add(1,0,4'h3, 16'hA987,0,2'd3,1,0,8'd2);
      add(1,0,4'h4, 16'h4321,1,2'd0,1,0,8'd2);
      // Back-to-back frames: frame_valid every 4th cycle
      add(1,1,4'hB, 16'h4321,0,2'd1,1,0,8'd2);
      add(1,0,4'hC, 16'h4321,0,2'd2,1,0,8'd2);
      add(1,0,4'hD, 16'h4321,0,2'd3,1,0,8'd2);
      add(1,0,4'hE, 16'hEDCB,1,2'd0,1,0,8'd2);
      add(1,1,4'h0, 16'hEDCB,0,2'd1,1,0,8'd2);
      add(1,0,4'h0, 16'hEDCB,0,2'd2,1,0,8'd2);
      add(1,0,4'h0, 16'hEDCB,0,2'd3,1,0,8'd2);
      add(1,0,4'h1, 16'h1000,1,2'd0,1,0,8'd2);
      add(0,0,4'h0, 16'h1000,0,2'd0,1,0,8'd2);

      rst = 1'b1;
      ifa.din_valid = 1'b0; ifa.sync = 1'b0; ifa.din = '0;
      ifb.din_valid = 1'b0; ifb.sync = 1'b0; ifb.din = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_a("reset", 16'h0, 0, 2'd0, 0, 0, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         beat_a(tbl[i].v, tbl[i].s, tbl[i].d);
         chk_a($sformatf("vec%0d", i), tbl[i].fo, tbl[i].fv, tbl[i].sl,
               tbl[i].lk, tbl[i].se, tbl[i].ec);
      end

      // Reset mid-frame: two slots in, then async reset wipes everything.
      beat_a(1, 1, 4'hE);
      beat_a(1, 0, 4'hF);
      chk("midrst.pre_slot", 32'(ifa.slot), 32'd2);
      @(negedge clk);
      ifa.din_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_a("midrst.async", 16'h0, 0, 2'd0, 0, 0, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      beat_a(1, 1, 4'h5);
      chk_a("clean.s0", 16'h0, 0, 2'd1, 1, 0, 8'd0);
      beat_a(1, 0, 4'h6);
      beat_a(1, 0, 4'h7);
      chk_a("clean.s2", 16'h0, 0, 2'd3, 1, 0, 8'd0);
      beat_a(1, 0, 4'h8);
      chk_a("clean.s3", 16'h8765, 1, 2'd0, 1, 0, 8'd0);
      beat_a(0, 0, 4'h0);
      chk("clean.fv_drop", 32'(ifa.frame_valid), 32'd0);

      // Saturation with ERRW=2: lock, then five early syncs.
      beat_b(1, 1, 4'h1);
      chk("sat.locked", 32'(ifb.locked), 32'd1);
      chk("sat.cnt0", 32'(ifb.err_count), 32'd0);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         beat_b(1, 1, 4'h2);
         if (ifb.sync_err === 1'b1) pulses++;
         chk($sformatf("sat.cnt%0d", k + 1), 32'(ifb.err_count),
             (k < 3) ? 32'(k + 1) : 32'd3);
      end
      beat_b(0, 0, 4'h0);
      chk("sat.pulses", 32'(pulses), 32'd5);
      chk("sat.err_drop", 32'(ifb.sync_err), 32'd0);
      chk("sat.final", 32'(ifb.err_count), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
